// File: rtl/ahb_pkg.sv
`default_nettype none
// =============================================================================
// ahb_pkg: shared constants, types and func3 helpers for the AHB master front-end.
// Rev 1.0
// =============================================================================
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ERR2 = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   function automatic logic [2:0] f3_to_hsize(input logic [2:0] f3);
      logic [2:0] size;
      case (f3[1:0])
         2'b00:   size = HSIZE_BYTE;
         2'b01:   size = HSIZE_HALF;
         default: size = HSIZE_WORD;
      endcase
      return size;
   endfunction

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic [2:0] size;
      size = f3_to_hsize(f3);
      return ((size == HSIZE_HALF) && lo[0]) || ((size == HSIZE_WORD) && (lo != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_master_ctrl_if.sv
`default_nettype none
// =============================================================================
// ahb_master_ctrl_if: core request ports and AHB-Lite bus bundled for the master.
// Rev 1.0
// =============================================================================
interface ahb_master_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_err;

   logic              d_req;
   logic              d_we;
   logic [2:0]        d_func3;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;

   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [31:0]       hwdata;
   logic [31:0]       hrdata;
   logic              hready;
   logic              hresp;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata,
             hrdata, hready, hresp,
      output if_gnt, if_rvalid, if_rdata, if_err,
             d_gnt, d_rvalid, d_rdata, d_err,
             haddr, htrans, hwrite, hsize, hwdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata,
             hrdata, hready, hresp,
      input  if_gnt, if_rvalid, if_rdata, if_err,
             d_gnt, d_rvalid, d_rdata, d_err,
             haddr, htrans, hwrite, hsize, hwdata
   );
endinterface
`default_nettype wire

// File: rtl/ahb_load_align.sv
`default_nettype none
// =============================================================================
// ahb_load_align: selects the addressed byte/half lane and sign/zero-extends it.
// Rev 1.0
// =============================================================================
module ahb_load_align
   import ahb_pkg::*;
(
   input  logic [31:0] hrdata_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] result_o
);
   logic [31:0] w_shifted;

   // Halves are always 2-byte aligned here, so a byte-granular shift covers both widths.
   assign w_shifted = hrdata_i >> {addr_i, 3'b000};

   always_comb begin
      result_o = w_shifted;
      case (func3_i)
         F3_LB:   result_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_LBU:  result_o = {24'h0, w_shifted[7:0]};
         F3_LH:   result_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_LHU:  result_o = {16'h0, w_shifted[15:0]};
         default: result_o = w_shifted;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/ahb_master_ctrl.sv
`default_nettype none
// =============================================================================
// ahb_master_ctrl: AHB-Lite master shared by instruction-fetch and load/store ports.
// Rev 1.0
// =============================================================================
module ahb_master_ctrl
   import ahb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   ahb_master_ctrl_if.master bus
);
   localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

   state_e            state_q, state_d;
   owner_e            own_q, own_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lo_q, lo_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic [1:0]        htrans_q, htrans_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [31:0]       hwdata_q, hwdata_d;
   logic              if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic              d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [31:0]       d_rdata_q, d_rdata_d;

   logic              w_d_bad, w_complete, w_err_first, w_slot, w_sel_d, w_d_gnt, w_if_gnt;
   logic [2:0]        w_d_hsize;
   logic [31:0]       w_store_lanes, w_load_data;

   assign w_d_hsize   = f3_to_hsize(bus.d_func3);
   assign w_d_bad     = !f3_legal(bus.d_func3) || f3_misaligned(bus.d_func3, bus.d_addr[1:0]);
   assign w_complete  = (state_q == DATA) && bus.hready;
   assign w_err_first = (state_q == DATA) && !bus.hready && bus.hresp;
   assign w_slot      = reset && ((state_q == IDLE) || (w_complete && !bus.hresp));
   assign w_sel_d     = bus.d_req && !(bus.if_req && (starve_q == STARVE_MAX));
   // A rejected data request reports next cycle, so hold it off while a data load also reports.
   assign w_d_gnt     = w_slot && w_sel_d && !(w_d_bad && w_complete && (own_q == OWN_D));
   assign w_if_gnt    = w_slot && bus.if_req && !w_sel_d;

   always_comb begin
      w_store_lanes = bus.d_wdata;
      case (w_d_hsize)
         HSIZE_BYTE: w_store_lanes = {4{bus.d_wdata[7:0]}};
         HSIZE_HALF: w_store_lanes = {2{bus.d_wdata[15:0]}};
         default:    w_store_lanes = bus.d_wdata;
      endcase
   end

   ahb_load_align u_align (
      .hrdata_i (bus.hrdata),
      .addr_i   (lo_q),
      .func3_i  (f3_q),
      .result_o (w_load_data)
   );

   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      we_d        = we_q;
      f3_d        = f3_q;
      lo_d        = lo_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hwdata_d    = hwdata_q;
      if_rvalid_d = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = 32'h0;
      d_rvalid_d  = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = 32'h0;
      starve_d    = starve_q;

      case (state_q)
         IDLE: ;
         DATA: begin
            if (bus.hready) begin
               state_d  = IDLE;
               htrans_d = HTRANS_IDLE;
               if (own_q == OWN_IF) begin
                  if_rvalid_d = 1'b1;
                  if_err_d    = bus.hresp;
                  if_rdata_d  = bus.hresp ? 32'h0 : bus.hrdata;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_err_d    = bus.hresp;
                  d_rdata_d  = (bus.hresp || we_q) ? 32'h0 : w_load_data;
               end
            end else if (bus.hresp) begin
               state_d  = ERR2;
               htrans_d = HTRANS_IDLE;
            end
         end
         ERR2: begin
            if (bus.hready) begin
               state_d = IDLE;
               if (own_q == OWN_IF) begin
                  if_rvalid_d = 1'b1;
                  if_err_d    = 1'b1;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_err_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (w_d_gnt) begin
         if (w_d_bad) begin
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
            d_rdata_d  = 32'h0;
         end else begin
            state_d  = DATA;
            own_d    = OWN_D;
            we_d     = bus.d_we;
            f3_d     = bus.d_func3;
            lo_d     = bus.d_addr[1:0];
            haddr_d  = bus.d_addr;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = bus.d_we;
            hsize_d  = w_d_hsize;
            if (bus.d_we) hwdata_d = w_store_lanes;
         end
      end else if (w_if_gnt) begin
         state_d  = DATA;
         own_d    = OWN_IF;
         we_d     = 1'b0;
         f3_d     = F3_LW;
         lo_d     = 2'b00;
         haddr_d  = bus.if_addr & WORD_MASK;
         htrans_d = HTRANS_NONSEQ;
         hwrite_d = 1'b0;
         hsize_d  = HSIZE_WORD;
      end

      if (w_if_gnt) begin
         starve_d = '0;
      end else if (bus.if_req && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         own_q       <= OWN_IF;
         we_q        <= 1'b0;
         f3_q        <= F3_LW;
         lo_q        <= 2'b00;
         starve_q    <= '0;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         hwrite_q    <= 1'b0;
         hsize_q     <= HSIZE_WORD;
         hwdata_q    <= 32'h0;
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         lo_q        <= lo_d;
         starve_q    <= starve_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hwdata_q    <= hwdata_d;
         if_rvalid_q <= if_rvalid_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         d_rvalid_q  <= d_rvalid_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.if_gnt    = w_if_gnt;
   assign bus.d_gnt     = w_d_gnt;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_err    = if_err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_err     = d_err_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.haddr     = haddr_q;
   // First ERROR cycle cancels the address phase immediately rather than one edge later.
   assign bus.htrans    = w_err_first ? HTRANS_IDLE : htrans_q;
   assign bus.hwrite    = hwrite_q;
   assign bus.hsize     = hsize_q;
   assign bus.hwdata    = hwdata_q;
endmodule
`default_nettype wire

// File: tb/tb_ahb_master_ctrl.sv
`default_nettype none
// =============================================================================
// tb_ahb_master_ctrl: directed vectors and sequences for the shared AHB master.
// Rev 1.0
// =============================================================================
module tb_ahb_master_ctrl;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] hrdata;
      logic        bad;
      logic [2:0]  hsize;
      logic [31:0] hwdata;
      logic [31:0] rdata;
   } vec_t;

   localparam int NV = 14;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vecs [NV];

   ahb_master_ctrl_if #(.ADDR_W(32)) bus ();

   ahb_master_ctrl #(
      .STARVE_LIMIT (4),
      .ADDR_W       (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int i);
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_func3 = v.f3;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(bus.d_gnt), 32'd1);
      step();
      bus.d_req = 1'b0;
      if (v.bad) begin
         #1;
         chk($sformatf("v%0d_htrans", i), 32'(bus.htrans), 32'd0);
         chk($sformatf("v%0d_rvalid", i), 32'(bus.d_rvalid), 32'd1);
         chk($sformatf("v%0d_err", i), 32'(bus.d_err), 32'd1);
         chk($sformatf("v%0d_rdata", i), bus.d_rdata, 32'h0);
      end else begin
         bus.hrdata = v.hrdata;
         bus.hready = 1'b1;
         #1;
         chk($sformatf("v%0d_htrans", i), 32'(bus.htrans), 32'd2);
         chk($sformatf("v%0d_haddr", i), bus.haddr, v.addr);
         chk($sformatf("v%0d_hwrite", i), 32'(bus.hwrite), 32'(v.we));
         chk($sformatf("v%0d_hsize", i), 32'(bus.hsize), 32'(v.hsize));
         if (v.we) chk($sformatf("v%0d_hwdata", i), bus.hwdata, v.hwdata);
         step();
         #1;
         chk($sformatf("v%0d_rvalid", i), 32'(bus.d_rvalid), 32'd1);
         chk($sformatf("v%0d_err", i), 32'(bus.d_err), 32'd0);
         chk($sformatf("v%0d_rdata", i), bus.d_rdata, v.rdata);
      end
      step();
      bus.hrdata = 32'h0;
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_haddr,
                           input logic [31:0] rdata, input string tag);
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
      #1;
      chk({tag, "_gnt"}, 32'(bus.if_gnt), 32'd1);
      step();
      bus.if_req = 1'b0;
      bus.hrdata = rdata;
      bus.hready = 1'b1;
      #1;
      chk({tag, "_htrans"}, 32'(bus.htrans), 32'd2);
      chk({tag, "_haddr"}, bus.haddr, exp_haddr);
      chk({tag, "_hsize"}, 32'(bus.hsize), 32'd2);
      step();
      #1;
      chk({tag, "_rvalid"}, 32'(bus.if_rvalid), 32'd1);
      chk({tag, "_rdata"}, bus.if_rdata, rdata);
      chk({tag, "_err"}, 32'(bus.if_err), 32'd0);
      step();
      #1;
      chk({tag, "_rvalid_pulse"}, 32'(bus.if_rvalid), 32'd0);
      bus.hrdata = 32'h0;
   endtask

   initial begin
      int lost;
      int dg;
      int cyc;
      logic got;

      checks   = 0;
      failures = 0;

      //           we    f3      addr          wdata         hrdata        bad   hsize   hwdata        rdata
      vecs[0]  = '{1'b1, 3'b010, 32'hB000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 3'b010, 32'h1234_5678, 32'h0000_0000};
      vecs[1]  = '{1'b0, 3'b000, 32'hB000_0003, 32'h0000_0000, 32'h8034_5678, 1'b0, 3'b000, 32'h0000_0000, 32'hFFFF_FF80};
      vecs[2]  = '{1'b0, 3'b100, 32'hB000_0003, 32'h0000_0000, 32'h8034_5678, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0080};
      vecs[3]  = '{1'b1, 3'b001, 32'hB000_0002, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 3'b001, 32'hBEEF_BEEF, 32'h0000_0000};
      vecs[4]  = '{1'b0, 3'b010, 32'hB000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'b010, 32'h0000_0000, 32'h0000_0000};
      vecs[5]  = '{1'b0, 3'b001, 32'hB000_0002, 32'h0000_0000, 32'h8001_1234, 1'b0, 3'b001, 32'h0000_0000, 32'hFFFF_8001};
      vecs[6]  = '{1'b0, 3'b101, 32'hB000_0000, 32'h0000_0000, 32'h8001_F234, 1'b0, 3'b001, 32'h0000_0000, 32'h0000_F234};
      vecs[7]  = '{1'b0, 3'b010, 32'hB000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b1, 3'b000, 32'hB000_0001, 32'h0000_00A5, 32'h0000_0000, 1'b0, 3'b000, 32'hA5A5_A5A5, 32'h0000_0000};
      vecs[9]  = '{1'b0, 3'b001, 32'hB000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'b001, 32'h0000_0000, 32'h0000_0000};
      vecs[10] = '{1'b0, 3'b011, 32'hB000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'b010, 32'h0000_0000, 32'h0000_0000};
      vecs[11] = '{1'b0, 3'b000, 32'hB000_0001, 32'h0000_0000, 32'h0000_7F00, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_007F};
      vecs[12] = '{1'b1, 3'b010, 32'hB000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b010, 32'h0000_0000, 32'h0000_0000};
      vecs[13] = '{1'b0, 3'b101, 32'hB000_0002, 32'h0000_0000, 32'h8001_1234, 1'b0, 3'b001, 32'h0000_0000, 32'h0000_8001};

      reset       = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'hA000_0000;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_func3 = 3'b010;
      bus.d_addr  = 32'hB000_0000;
      bus.d_wdata = 32'h0;
      bus.hrdata  = 32'h0;
      bus.hready  = 1'b1;
      bus.hresp   = 1'b0;
      step();
      step();
      #1;
      chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
      chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      chk("rst_htrans", 32'(bus.htrans), 32'd0);
      chk("rst_haddr", bus.haddr, 32'h0);
      chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
      chk("rst_hsize", 32'(bus.hsize), 32'd2);
      chk("rst_hwdata", bus.hwdata, 32'h0);
      chk("rst_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
      chk("rst_err", {30'h0, bus.if_err, bus.d_err}, 32'h0);
      chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      reset      = 1'b1;
      step();

      do_fetch(32'hA000_0004, 32'hA000_0004, 32'h0000_0013, "fetch1");
      do_fetch(32'hA000_0007, 32'hA000_0004, 32'h1111_2222, "fetch_lowbits");

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Starvation: back-to-back loads against a held fetch.
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_func3 = 3'b010;
      bus.d_addr  = 32'hB000_0010;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'hA000_0000;
      bus.hrdata  = 32'h5555_AAAA;
      bus.hready  = 1'b1;
      got  = 1'b0;
      lost = 0;
      dg   = 0;
      cyc  = 0;
      while (!got && cyc < 12) begin
         #1;
         if (cyc >= 1) chk($sformatf("b2b_htrans_c%0d", cyc), 32'(bus.htrans), 32'd2);
         if (bus.d_gnt) dg++;
         if (bus.if_gnt) got = 1'b1;
         else begin
            lost++;
            step();
         end
         cyc++;
      end
      chk("starve_lost", 32'(lost), 32'd4);
      chk("starve_d_gnts", 32'(dg), 32'd4);
      step();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      bus.hrdata = 32'h7777_0001;
      #1;
      chk("starve_fetch_haddr", bus.haddr, 32'hA000_0000);
      chk("starve_last_load_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("starve_last_load_rdata", bus.d_rdata, 32'h5555_AAAA);
      step();
      #1;
      chk("starve_fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("starve_fetch_rdata", bus.if_rdata, 32'h7777_0001);
      step();
      bus.hrdata = 32'h0;

      // Three wait states on a load.
      bus.d_req   = 1'b1;
      bus.d_func3 = 3'b010;
      bus.d_addr  = 32'hB000_0008;
      #1;
      chk("ws_gnt", 32'(bus.d_gnt), 32'd1);
      step();
      bus.d_req  = 1'b0;
      bus.hready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         #1;
         chk($sformatf("ws_htrans_%0d", w), 32'(bus.htrans), 32'd2);
         chk($sformatf("ws_haddr_%0d", w), bus.haddr, 32'hB000_0008);
         chk($sformatf("ws_rvalid_%0d", w), 32'(bus.d_rvalid), 32'd0);
         step();
      end
      bus.hready = 1'b1;
      bus.hrdata = 32'h1122_3344;
      step();
      #1;
      chk("ws_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("ws_rdata", bus.d_rdata, 32'h1122_3344);
      step();
      bus.hrdata = 32'h0;

      // Two-cycle ERROR response on a load.
      bus.d_req  = 1'b1;
      bus.d_addr = 32'hB000_000C;
      #1;
      chk("err_gnt", 32'(bus.d_gnt), 32'd1);
      step();
      bus.d_req  = 1'b0;
      bus.hready = 1'b0;
      bus.hresp  = 1'b1;
      #1;
      chk("err_c1_htrans", 32'(bus.htrans), 32'd0);
      chk("err_c1_rvalid", 32'(bus.d_rvalid), 32'd0);
      step();
      bus.hready = 1'b1;
      #1;
      chk("err_c2_htrans", 32'(bus.htrans), 32'd0);
      chk("err_c2_rvalid", 32'(bus.d_rvalid), 32'd0);
      step();
      bus.hresp = 1'b0;
      #1;
      chk("err_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("err_err", 32'(bus.d_err), 32'd1);
      chk("err_rdata", bus.d_rdata, 32'h0);
      step();
      #1;
      chk("err_rvalid_pulse", 32'(bus.d_rvalid), 32'd0);

      // Reset while a fetch data phase is outstanding.
      bus.if_req  = 1'b1;
      bus.if_addr = 32'hA000_0008;
      #1;
      chk("mrst_gnt", 32'(bus.if_gnt), 32'd1);
      step();
      reset      = 1'b0;
      bus.hrdata = 32'hCAFE_F00D;
      bus.hready = 1'b1;
      #1;
      chk("mrst_gnt_forced", 32'(bus.if_gnt), 32'd0);
      step();
      #1;
      chk("mrst_htrans", 32'(bus.htrans), 32'd0);
      chk("mrst_haddr", bus.haddr, 32'h0);
      chk("mrst_hsize", 32'(bus.hsize), 32'd2);
      chk("mrst_rvalid", 32'(bus.if_rvalid), 32'd0);
      bus.if_req = 1'b0;
      reset      = 1'b1;
      step();
      #1;
      chk("mrst_no_late_rvalid", 32'(bus.if_rvalid), 32'd0);
      bus.hrdata = 32'h0;
      do_fetch(32'hA000_000C, 32'hA000_000C, 32'h0BAD_C0DE, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_master_ctrl.md
Name: ahb_master_ctrl

Overview:
- Single AHB-Lite master front-end shared by the core's instruction-fetch port and its load/store port.
- Arbitrates between the two ports, issues pipelined NONSEQ single transfers with HREADY stall handling, and lane-replicates store data.
- Aligns and extends load data per func3, and reports bus or alignment errors.
- Sits between the core and the AHB interconnect that decodes ROM (0xA000_xxxx) and RAM (0xB000_xxxx).

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose arbitration before it takes priority.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch address; bits [1:0] are ignored and driven as 0.
- if_gnt  out  1  fetch address phase accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: fetch completed.
- if_rdata  out  32  fetch data, valid with if_rvalid.
- if_err  out  1  qualifies if_rvalid: bus ERROR.
- d_req  in  1  data request; held with d_we/d_func3/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  RISC-V width code.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, LSB-aligned.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: data access completed (loads and stores).
- d_rdata  out  32  extended load data; 0 for stores and errors.
- d_err  out  1  qualifies d_rvalid: misaligned, illegal func3, or bus ERROR.
- haddr  out  32  AHB address.
- htrans  out  2  IDLE = 00 or NONSEQ = 10 only.
- hwrite  out  1  AHB write.
- hsize  out  3  000 byte, 001 half, 010 word.
- hwdata  out  32  AHB write data.
- hrdata  in  32  AHB read data.
- hready  in  1  transfer done / bus ready.
- hresp  in  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset values (reset = 0 at a clk edge):
  - htrans = 00, haddr = 0, hwrite = 0, hsize = 010, hwdata = 0.
  - All rvalid, err and rdata outputs = 0.
  - Starve counter = 0; FSM = IDLE.
  - Gnt outputs are forced to 0 while reset = 0.
- Reset mid-transfer: the outstanding transfer is dropped and no rvalid is issued.
- FSM states:
  - IDLE: no data phase pending.
  - DATA: a data phase is outstanding.
  - ERR2: second cycle of an ERROR response.
- Issue and grant:
  - A new address phase may be issued in IDLE, or in DATA in the same cycle hready = 1 completes the previous transfer (pipelined).
  - Never issued in ERR2, or in DATA while hready = 0.
  - gnt is combinational and asserts in the issuing cycle. The address-phase registers (haddr, htrans, hwrite, hsize) are loaded at that edge.
  - With no request, htrans = IDLE.
- Arbitration:
  - d_req wins over if_req unless the starve counter equals STARVE_LIMIT; then if_req wins.
  - The counter increments each cycle if_req = 1 and if_gnt = 0, saturates at STARVE_LIMIT, and clears on if_gnt.
- Data-request func3 handling:
  - 000 LB/SB and 100 LBU: byte.
  - 001 LH/SH and 101 LHU: half.
  - 010 LW/SW: word.
  - Other func3 values are illegal.
- Data-request misalignment: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
- Illegal or misaligned data requests:
  - d_gnt is asserted but no bus transfer is issued.
  - d_rvalid = d_err = 1 and d_rdata = 0 the following cycle.
  - A fetch may not be issued in the same cycle.
- Stores: hwdata is driven in the data phase from data latched at grant.
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Loads: on the data-phase completion edge (hready = 1, hresp = 0), the lane is selected by the latched addr[1:0].
  - Zero- or sign-extended per func3.
  - Registered to d_rdata with d_rvalid = 1 next cycle.
- Fetches: always word; if_rvalid/if_rdata follow the same one-cycle registered timing.
- Latency (zero wait): grant in cycle N, data phase in N+1, rvalid in N+2.
- Wait states: each hready = 0 cycle adds one cycle; address-phase outputs hold.
- ERROR response:
  - Cycle 1 (hready = 0, hresp = 1): htrans is forced to IDLE and the FSM goes to ERR2.
  - Cycle 2 (hready = 1, hresp = 1): the owning port's rvalid and err pulse next cycle, rdata = 0.
- Each port has at most one outstanding transfer.
- Simultaneous d_req and if_req: the loser stays pending and is considered again in the next issue slot.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD.
  - F3_LB, F3_LH, F3_LW, F3_LBU and F3_LHU.
  - FSM state enum (IDLE, DATA, ERR2).
  - Owner encoding (OWN_IF, OWN_D).
- Sub-module ahb_load_align: combinational lane select plus sign/zero extension.
  - Inputs: hrdata, addr[1:0], func3.
  - Output: 32-bit result.

Test Plan:
1. Fetch 0xA000_0004, hrdata = 0x0000_0013, hready = 1 -> htrans = 10, haddr = 0xA000_0004, hsize = 010; if_rvalid two cycles after if_gnt with if_rdata = 0x0000_0013.
2. SW 0xB000_0000, wdata 0x1234_5678, then LB 0xB000_0003 with hrdata = 0x8034_5678 -> hwdata = 0x1234_5678 in the SW data phase; load returns d_rdata = 0xFFFF_FF80. LBU at the same address returns 0x0000_0080.
3. SH 0xB000_0002, wdata 0x0000_BEEF -> hsize = 001, hwdata = 0xBEEF_BEEF. LW 0xB000_0002 -> d_err = 1, d_rvalid = 1, no NONSEQ issued.
4. d_req and if_req both held high with back-to-back loads -> fetch is granted after exactly 4 lost cycles. Verify back-to-back pipelined NONSEQs with hready = 1.
5. hready = 0 for 3 cycles in a data phase -> haddr/htrans held; rvalid delayed 3 cycles. ERROR response (hresp = 1 for 2 cycles) -> htrans = 00 in the first cycle, then d_err pulse.
6. reset = 0 while in DATA -> next cycle htrans = 00, no rvalid, all outputs at reset values; normal fetch succeeds after reset = 1.
